// File: rtl/mem_responder_if.sv
// Request/response channel between a memory master (core) and the mem_responder slave.
interface mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_wr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_mask;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_wr;
  logic                    resp_err;

  modport master (
    output req_valid, req_addr, req_wr, req_wdata, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_wr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wr, req_wdata, req_mask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_wr, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory slave: byte-masked writes, reads sampled at accept,
// fixed-latency shift pipeline feeding a response FIFO bounded by an outstanding counter.
module mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  accept;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]      word_idx;
  logic                  misaligned;
  logic                  out_of_range;

  logic                  vld_p0;
  logic                  wr_p0;
  logic                  err_p0;
  logic [DATA_WIDTH-1:0] rdata_p0;

  logic                  push_vld;
  logic                  push_wr;
  logic                  push_err;
  logic [DATA_WIDTH-1:0] push_rdata;

  logic [DATA_WIDTH-1:0] fifo_rdata [RESP_DEPTH];
  logic                  fifo_wr    [RESP_DEPTH];
  logic                  fifo_err   [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W-1:0]      outstanding;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept       = bus.req_valid && bus.req_ready;
  assign pop          = bus.resp_valid && bus.resp_ready;
  assign word_addr    = bus.req_addr >> OFF_W;
  assign word_idx     = word_addr[IDX_W-1:0];
  assign misaligned   = (bus.req_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = word_addr >= ADDR_WIDTH'(MEM_WORDS);

  // Stage p0: address check and array read at the accept edge
  assign vld_p0   = accept;
  assign wr_p0    = bus.req_wr;
  assign err_p0   = misaligned || out_of_range;
  assign rdata_p0 = (err_p0 || wr_p0) ? '0 : mem[word_idx];

  always_ff @(posedge clk) begin
    if (accept && wr_p0 && !err_p0) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.req_mask[i]) begin
          mem[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stages p1..p(LATENCY-1): non-stalling shift toward the response FIFO
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push_vld   = vld_p0;
      assign push_wr    = wr_p0;
      assign push_err   = err_p0;
      assign push_rdata = rdata_p0;
    end else begin : g_pipe
      logic                  vld_pn   [LATENCY-1];
      logic                  wr_pn    [LATENCY-1];
      logic                  err_pn   [LATENCY-1];
      logic [DATA_WIDTH-1:0] rdata_pn [LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY - 1; i++) vld_pn[i] <= 1'b0;
        end else begin
          vld_pn[0] <= vld_p0;
          for (int i = 1; i < LATENCY - 1; i++) vld_pn[i] <= vld_pn[i-1];
        end
      end

      always_ff @(posedge clk) begin
        wr_pn[0]    <= wr_p0;
        err_pn[0]   <= err_p0;
        rdata_pn[0] <= rdata_p0;
        for (int i = 1; i < LATENCY - 1; i++) begin
          wr_pn[i]    <= wr_pn[i-1];
          err_pn[i]   <= err_pn[i-1];
          rdata_pn[i] <= rdata_pn[i-1];
        end
      end

      assign push_vld   = vld_pn[LATENCY-2];
      assign push_wr    = wr_pn[LATENCY-2];
      assign push_err   = err_pn[LATENCY-2];
      assign push_rdata = rdata_pn[LATENCY-2];
    end
  endgenerate

  // Response FIFO: occupancy never exceeds outstanding, so push never meets a full buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (push_vld) wr_ptr <= next_ptr(wr_ptr);
      if (pop)      rd_ptr <= next_ptr(rd_ptr);
      case ({push_vld, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_wr[wr_ptr]    <= push_wr;
      fifo_err[wr_ptr]   <= push_err;
    end
  end

  // Outputs are forced to zero when empty so unreset FIFO storage never shows through
  assign bus.req_ready  = !reset && (outstanding < CNT_W'(RESP_DEPTH));
  assign bus.resp_valid = fifo_cnt != '0;
  assign bus.resp_rdata = bus.resp_valid ? fifo_rdata[rd_ptr] : '0;
  assign bus.resp_wr    = bus.resp_valid && fifo_wr[rd_ptr];
  assign bus.resp_err   = bus.resp_valid && fifo_err[rd_ptr];

endmodule
